// File: rtl/dma_if_desc_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_if_desc_rd_arb_if
// Description : Bundle of the descriptor and status buses between the per-port
//               DMA clients, the read-descriptor arbiter and the read engine.
//               slave  = arbiter view, master = client/engine (environment) view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_if_desc_rd_arb_if #(
    parameter int PORTS           = 4,
    parameter int CL_PORTS        = $clog2(PORTS),
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int S_RAM_SEL_WIDTH = 2,
    parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + CL_PORTS,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int S_TAG_WIDTH     = 8,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS
);
    // per-port descriptor inputs (port 0 in the LSBs)
    logic [PORTS*PCIE_ADDR_WIDTH-1:0] s_axis_read_desc_pcie_addr;
    logic [PORTS*S_RAM_SEL_WIDTH-1:0] s_axis_read_desc_ram_sel;
    logic [PORTS*RAM_ADDR_WIDTH-1:0]  s_axis_read_desc_ram_addr;
    logic [PORTS*LEN_WIDTH-1:0]       s_axis_read_desc_len;
    logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_read_desc_tag;
    logic [PORTS-1:0]                 s_axis_read_desc_valid;
    logic [PORTS-1:0]                 s_axis_read_desc_ready;

    // merged descriptor towards the engine
    logic [PCIE_ADDR_WIDTH-1:0]       m_axis_read_desc_pcie_addr;
    logic [M_RAM_SEL_WIDTH-1:0]       m_axis_read_desc_ram_sel;
    logic [RAM_ADDR_WIDTH-1:0]        m_axis_read_desc_ram_addr;
    logic [LEN_WIDTH-1:0]             m_axis_read_desc_len;
    logic [M_TAG_WIDTH-1:0]           m_axis_read_desc_tag;
    logic                             m_axis_read_desc_valid;
    logic                             m_axis_read_desc_ready;

    // completion status from the engine and its per-port fan-out
    logic [M_TAG_WIDTH-1:0]           s_axis_read_desc_status_tag;
    logic                             s_axis_read_desc_status_valid;
    logic [PORTS*S_TAG_WIDTH-1:0]     m_axis_read_desc_status_tag;
    logic [PORTS-1:0]                 m_axis_read_desc_status_valid;

    modport slave (
        input  s_axis_read_desc_pcie_addr, s_axis_read_desc_ram_sel,
               s_axis_read_desc_ram_addr, s_axis_read_desc_len,
               s_axis_read_desc_tag, s_axis_read_desc_valid,
        output s_axis_read_desc_ready,
        output m_axis_read_desc_pcie_addr, m_axis_read_desc_ram_sel,
               m_axis_read_desc_ram_addr, m_axis_read_desc_len,
               m_axis_read_desc_tag, m_axis_read_desc_valid,
        input  m_axis_read_desc_ready,
        input  s_axis_read_desc_status_tag, s_axis_read_desc_status_valid,
        output m_axis_read_desc_status_tag, m_axis_read_desc_status_valid
    );

    modport master (
        output s_axis_read_desc_pcie_addr, s_axis_read_desc_ram_sel,
               s_axis_read_desc_ram_addr, s_axis_read_desc_len,
               s_axis_read_desc_tag, s_axis_read_desc_valid,
        input  s_axis_read_desc_ready,
        input  m_axis_read_desc_pcie_addr, m_axis_read_desc_ram_sel,
               m_axis_read_desc_ram_addr, m_axis_read_desc_len,
               m_axis_read_desc_tag, m_axis_read_desc_valid,
        output m_axis_read_desc_ready,
        output s_axis_read_desc_status_tag, s_axis_read_desc_status_valid,
        input  m_axis_read_desc_status_tag, m_axis_read_desc_status_valid
    );
endinterface
`default_nettype wire

// File: rtl/dma_if_desc_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : dma_if_desc_rd_arb
// Description : Round-robin arbiter sharing one PCIe DMA read engine between
//               PORTS requesters. Tags and RAM selects are prefixed with the
//               winning port; engine status is routed back by that prefix.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_if_desc_rd_arb #(
    parameter int PORTS           = 4,
    parameter int CL_PORTS        = $clog2(PORTS),
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int S_RAM_SEL_WIDTH = 2,
    parameter int M_RAM_SEL_WIDTH = S_RAM_SEL_WIDTH + CL_PORTS,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int S_TAG_WIDTH     = 8,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               enable,
    dma_if_desc_rd_arb_if.slave     bus
);

    logic [CL_PORTS-1:0]        ptr;
    logic [CL_PORTS-1:0]        grant_idx;
    logic                       grant_found;
    logic                       accept;
    logic                       transfer;
    logic [CL_PORTS-1:0]        ptr_next;

    logic                       m_valid_reg;
    logic [PCIE_ADDR_WIDTH-1:0] m_pcie_addr_reg;
    logic [M_RAM_SEL_WIDTH-1:0] m_ram_sel_reg;
    logic [RAM_ADDR_WIDTH-1:0]  m_ram_addr_reg;
    logic [LEN_WIDTH-1:0]       m_len_reg;
    logic [M_TAG_WIDTH-1:0]     m_tag_reg;

    logic [PORTS-1:0]             status_valid_reg;
    logic [PORTS*S_TAG_WIDTH-1:0] status_tag_reg;
    logic [CL_PORTS-1:0]          status_port;

    // The output register can take a new descriptor when empty or draining.
    assign accept   = enable && (!m_valid_reg || bus.m_axis_read_desc_ready);
    assign transfer = accept && grant_found;

    // Round-robin scan starting at ptr; descending loop lets the smallest offset win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (bus.s_axis_read_desc_valid[(int'(ptr) + i) % PORTS]) begin
                grant_found = 1'b1;
                grant_idx   = CL_PORTS'((int'(ptr) + i) % PORTS);
            end
        end
    end

    // Pointer moves to the port just after the winner.
    always_comb begin
        ptr_next = '0;
        if (int'(grant_idx) != PORTS - 1) begin
            ptr_next = grant_idx + CL_PORTS'(1);
        end
    end

    // One-hot ready for the selected port; forced low while reset is held.
    always_comb begin
        bus.s_axis_read_desc_ready = '0;
        if (transfer && !rst) begin
            bus.s_axis_read_desc_ready[grant_idx] = 1'b1;
        end
    end

    // Control state: output valid and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            ptr         <= '0;
        end else if (transfer) begin
            m_valid_reg <= 1'b1;
            ptr         <= ptr_next;
        end else if (bus.m_axis_read_desc_ready) begin
            m_valid_reg <= 1'b0;
        end
    end

    // Descriptor payload capture; contents are qualified by m_valid_reg so no reset.
    always_ff @(posedge clk) begin
        if (transfer) begin
            m_pcie_addr_reg <= bus.s_axis_read_desc_pcie_addr[grant_idx*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
            m_ram_sel_reg   <= {grant_idx, bus.s_axis_read_desc_ram_sel[grant_idx*S_RAM_SEL_WIDTH +: S_RAM_SEL_WIDTH]};
            m_ram_addr_reg  <= bus.s_axis_read_desc_ram_addr[grant_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            m_len_reg       <= bus.s_axis_read_desc_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
            m_tag_reg       <= {grant_idx, bus.s_axis_read_desc_tag[grant_idx*S_TAG_WIDTH +: S_TAG_WIDTH]};
        end
    end

    assign bus.m_axis_read_desc_valid     = m_valid_reg;
    assign bus.m_axis_read_desc_pcie_addr = m_pcie_addr_reg;
    assign bus.m_axis_read_desc_ram_sel   = m_ram_sel_reg;
    assign bus.m_axis_read_desc_ram_addr  = m_ram_addr_reg;
    assign bus.m_axis_read_desc_len       = m_len_reg;
    assign bus.m_axis_read_desc_tag       = m_tag_reg;

    // Status routing: the tag's top bits name the originating port.
    assign status_port = bus.s_axis_read_desc_status_tag[M_TAG_WIDTH-1 -: CL_PORTS];

    // Registered one-cycle status strobe; out-of-range ports are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_valid_reg <= '0;
        end else begin
            status_valid_reg <= '0;
            if (bus.s_axis_read_desc_status_valid && int'(status_port) < PORTS) begin
                status_valid_reg[status_port] <= 1'b1;
            end
        end
    end

    // Status tag slot of the addressed port; qualified by its strobe so no reset.
    always_ff @(posedge clk) begin
        if (bus.s_axis_read_desc_status_valid && int'(status_port) < PORTS) begin
            status_tag_reg[status_port*S_TAG_WIDTH +: S_TAG_WIDTH] <=
                bus.s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
        end
    end

    assign bus.m_axis_read_desc_status_valid = status_valid_reg;
    assign bus.m_axis_read_desc_status_tag   = status_tag_reg;

endmodule
`default_nettype wire

// File: tb/tb_dma_if_desc_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_if_desc_rd_arb
// Description : Self-checking bench for dma_if_desc_rd_arb: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_if_desc_rd_arb;

    localparam int PORTS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    int vectors = 0;
    int fails   = 0;

    dma_if_desc_rd_arb_if #(.PORTS(PORTS)) bus ();

    dma_if_desc_rd_arb #(.PORTS(PORTS)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requesting port scanning p, p+1, ... mod 4; -1 if none.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    logic        mv;
    int          mptr;
    logic [63:0] e_addr;
    int          e_sel, e_raddr, e_len, e_tag;
    logic [3:0]  msv;
    int          mst [4];
    int          cand;

    always_comb cand = pick(bus.s_axis_read_desc_valid, mptr);

    // Transaction-level model: an accepted request of port k becomes the output
    // with k prefixed onto tag and ram_sel; the pointer moves past k.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv   <= 1'b0;
            mptr <= 0;
            msv  <= '0;
        end else begin
            if (en && (!mv || bus.m_axis_read_desc_ready) && cand >= 0) begin
                mv      <= 1'b1;
                mptr    <= (cand + 1) % 4;
                e_addr  <= bus.s_axis_read_desc_pcie_addr[cand*64 +: 64];
                e_sel   <= cand * 4   + int'(bus.s_axis_read_desc_ram_sel[cand*2 +: 2]);
                e_raddr <= int'(bus.s_axis_read_desc_ram_addr[cand*16 +: 16]);
                e_len   <= int'(bus.s_axis_read_desc_len[cand*16 +: 16]);
                e_tag   <= cand * 256 + int'(bus.s_axis_read_desc_tag[cand*8 +: 8]);
            end else if (bus.m_axis_read_desc_ready) begin
                mv <= 1'b0;
            end
            if (bus.s_axis_read_desc_status_valid) begin
                msv <= 4'(1 << (int'(bus.s_axis_read_desc_status_tag) / 256));
                mst[int'(bus.s_axis_read_desc_status_tag) / 256] <= int'(bus.s_axis_read_desc_status_tag) % 256;
            end else begin
                msv <= '0;
            end
        end
    end

    // Compare process: every negedge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            logic [3:0] er;
            er = '0;
            if (en && (!mv || bus.m_axis_read_desc_ready) && cand >= 0) er = 4'(1 << cand);
            chk("m_valid", 64'(bus.m_axis_read_desc_valid), 64'(mv));
            if (mv) begin
                chk("m_pcie_addr", bus.m_axis_read_desc_pcie_addr, e_addr);
                chk("m_ram_sel",   64'(bus.m_axis_read_desc_ram_sel),  64'(e_sel));
                chk("m_ram_addr",  64'(bus.m_axis_read_desc_ram_addr), 64'(e_raddr));
                chk("m_len",       64'(bus.m_axis_read_desc_len),      64'(e_len));
                chk("m_tag",       64'(bus.m_axis_read_desc_tag),      64'(e_tag));
            end
            chk("s_ready",      64'(bus.s_axis_read_desc_ready),        64'(er));
            chk("status_valid", 64'(bus.m_axis_read_desc_status_valid), 64'(msv));
            for (int p = 0; p < 4; p++) begin
                if (msv[p]) chk("status_tag", 64'(bus.m_axis_read_desc_status_tag[p*8 +: 8]), 64'(mst[p]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int k, input logic [7:0] tag, input logic [1:0] sel);
        bus.s_axis_read_desc_tag[k*8 +: 8]          = tag;
        bus.s_axis_read_desc_ram_sel[k*2 +: 2]      = sel;
        bus.s_axis_read_desc_pcie_addr[k*64 +: 64]  = {$urandom, $urandom};
        bus.s_axis_read_desc_ram_addr[k*16 +: 16]   = 16'($urandom);
        bus.s_axis_read_desc_len[k*16 +: 16]        = 16'($urandom);
    endtask

    logic [9:0] held;

    initial begin
        bus.s_axis_read_desc_valid        = 4'hF;
        bus.m_axis_read_desc_ready        = 1'b1;
        bus.s_axis_read_desc_status_valid = 1'b0;
        bus.s_axis_read_desc_status_tag   = '0;
        for (int k = 0; k < 4; k++) set_port(k, 8'(8'h10 + k), 2'(k));
        en = 1'b1;

        // Reset state while rst is held
        #12;
        chk("rst m_valid",      64'(bus.m_axis_read_desc_valid), 64'd0);
        chk("rst status_valid", 64'(bus.m_axis_read_desc_status_valid), 64'd0);
        chk("rst s_ready",      64'(bus.s_axis_read_desc_ready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Round robin: all ports valid, engine ready
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr tag", 64'(bus.m_axis_read_desc_tag), 64'((i % 4) * 256 + 16 + (i % 4)));
        end

        // Backpressure: engine stalls for 5 cycles
        step();
        bus.m_axis_read_desc_ready = 1'b0;
        @(negedge clk);
        held = bus.m_axis_read_desc_tag;
        chk("bp held tag", 64'(held), 64'h111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp stable tag", 64'(bus.m_axis_read_desc_tag), 64'(held));
            chk("bp no ready",   64'(bus.s_axis_read_desc_ready), 64'd0);
        end
        step();
        bus.m_axis_read_desc_ready = 1'b1;
        @(negedge clk);
        chk("bp resume ready", 64'(bus.s_axis_read_desc_ready), 64'b0100);
        @(negedge clk);
        chk("bp resume tag", 64'(bus.m_axis_read_desc_tag), 64'h212);

        // Single requester on port 2
        step();
        bus.s_axis_read_desc_valid = 4'b0100;
        set_port(2, 8'h5A, 2'd1);
        @(negedge clk);
        chk("single ready", 64'(bus.s_axis_read_desc_ready), 64'b0100);
        @(negedge clk);
        chk("single tag",     64'(bus.m_axis_read_desc_tag),     64'h25A);
        chk("single ram_sel", 64'(bus.m_axis_read_desc_ram_sel), 64'h9);
        step();
        bus.s_axis_read_desc_valid = 4'b0000;

        // Status demux, consecutive strobes
        bus.s_axis_read_desc_status_valid = 1'b1;
        bus.s_axis_read_desc_status_tag   = 10'h3C7;
        step();
        bus.s_axis_read_desc_status_tag   = 10'h005;
        @(negedge clk);
        chk("st valid p3", 64'(bus.m_axis_read_desc_status_valid), 64'b1000);
        chk("st tag p3",   64'(bus.m_axis_read_desc_status_tag[31:24]), 64'hC7);
        step();
        bus.s_axis_read_desc_status_tag   = 10'h10A;
        @(negedge clk);
        chk("st valid p0", 64'(bus.m_axis_read_desc_status_valid), 64'b0001);
        chk("st tag p0",   64'(bus.m_axis_read_desc_status_tag[7:0]), 64'h05);
        step();
        bus.s_axis_read_desc_status_valid = 1'b0;
        @(negedge clk);
        chk("st valid p1", 64'(bus.m_axis_read_desc_status_valid), 64'b0010);
        chk("st tag p1",   64'(bus.m_axis_read_desc_status_tag[15:8]), 64'h0A);

        // enable=0: held output drains, no new grants
        step();
        bus.m_axis_read_desc_ready = 1'b0;
        bus.s_axis_read_desc_valid = 4'b0010;
        step();
        en = 1'b0;
        bus.s_axis_read_desc_valid = 4'hF;
        @(negedge clk);
        chk("dis held valid", 64'(bus.m_axis_read_desc_valid), 64'd1);
        chk("dis no ready",   64'(bus.s_axis_read_desc_ready), 64'd0);
        step();
        bus.m_axis_read_desc_ready = 1'b1;
        @(negedge clk);
        chk("dis no ready2",  64'(bus.s_axis_read_desc_ready), 64'd0);
        @(negedge clk);
        chk("dis drained",    64'(bus.m_axis_read_desc_valid), 64'd0);

        // Reset mid-operation with an output pending
        step();
        en = 1'b1;
        bus.m_axis_read_desc_ready = 1'b0;
        for (int k = 0; k < 4; k++) set_port(k, 8'(8'h10 + k), 2'(k));
        @(negedge clk);
        @(negedge clk);
        chk("pre-rst valid", 64'(bus.m_axis_read_desc_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-rst valid", 64'(bus.m_axis_read_desc_valid), 64'd0);
        chk("mid-rst ready", 64'(bus.s_axis_read_desc_ready), 64'd0);
        step();
        rst = 1'b0;
        bus.m_axis_read_desc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post-rst port0", 64'(bus.m_axis_read_desc_tag), 64'h010);

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            step();
            bus.s_axis_read_desc_valid        = 4'($urandom);
            bus.m_axis_read_desc_ready        = ($urandom_range(0, 9) < 7);
            en                                = ($urandom_range(0, 9) < 9);
            bus.s_axis_read_desc_status_valid = 1'($urandom);
            bus.s_axis_read_desc_status_tag   = 10'($urandom);
            for (int k = 0; k < 4; k++) set_port(k, 8'($urandom), 2'($urandom));
        end
        step();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
